// File: rtl/y86_seq_sequencer.sv
// Multi-cycle stage sequencer and architectural-state holder (PC, CC, Status, retired count) for the Y86-64 SEQ core.
// Optional MEMORY-state watchdog is enabled by defining Y86_SEQ_MEM_WATCHDOG_EN.
module y86_seq_sequencer #(
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       IMEM_BYTES  = 256,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       CNT_W       = 32,
  parameter int unsigned       MEM_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [3:0]        icode_i,
  input  logic              fetch_hlt_i,
  input  logic              fetch_ins_i,
  input  logic              fetch_adr_i,
  input  logic              data_mem_error_i,
  input  logic              mem_ready_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic [2:0]        cc_next_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        cc_o,
  output logic [2:0]        stage_o,
  output logic              fetch_en_o,
  output logic              decode_en_o,
  output logic              execute_en_o,
  output logic              mem_req_o,
  output logic              wb_en_o,
  output logic              pc_en_o,
  output logic [3:0]        status_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_count_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_STOP      = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ST_AOK = 4'd1,
    ST_ADR = 4'd2,
    ST_INS = 4'd3,
    ST_HLT = 4'd4
  } status_e;

  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_BYTES);
  localparam logic [3:0]        ICODE_OPQ  = 4'h6;

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        cc_q, cc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              fetch_en_q, decode_en_q, execute_en_q;
  logic              mem_req_q, wb_en_q, pc_en_q, halted_q;
  logic              wdog_expired;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory.
  function automatic logic needs_mem(input logic [3:0] ic);
    case (ic)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: needs_mem = 1'b1;
      default:                            needs_mem = 1'b0;
    endcase
  endfunction

`ifdef Y86_SEQ_MEM_WATCHDOG_EN
  localparam int unsigned    WD_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  // Counts completed MEMORY cycles; held at zero elsewhere so it is clear on entry.
  logic [WD_W-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = '0;
    if (state_q == S_MEMORY && wdog_q != WD_LAST) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_expired = (wdog_q == WD_LAST);
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    pc_d      = pc_q;
    cc_d      = cc_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_hlt_i) begin
          status_d  = ST_HLT;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_STOP;
        end else if (fetch_ins_i) begin
          status_d = ST_INS;
          state_d  = S_STOP;
        end else if (fetch_adr_i || pc_q >= IMEM_LIMIT) begin
          status_d = ST_ADR;
          state_d  = S_STOP;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (icode_i == ICODE_OPQ) begin
          cc_d = cc_next_i;
        end
        state_d = needs_mem(icode_i) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        // A late MemReady in the final allowed cycle still wins over the watchdog.
        if (mem_ready_i) begin
          if (data_mem_error_i) begin
            status_d = ST_ADR;
            state_d  = S_STOP;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wdog_expired) begin
          status_d = ST_ADR;
          state_d  = S_STOP;
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_d      = new_pc_i;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_STOP;
      end
    endcase
  end

  // Strobes are registered from the next state so each one is a clean Moore output of state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      status_q     <= ST_AOK;
      pc_q         <= RESET_PC;
      cc_q         <= 3'b000;
      retired_q    <= '0;
      fetch_en_q   <= 1'b0;
      decode_en_q  <= 1'b0;
      execute_en_q <= 1'b0;
      mem_req_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      pc_en_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      pc_q         <= pc_d;
      cc_q         <= cc_d;
      retired_q    <= retired_d;
      fetch_en_q   <= (state_d == S_FETCH);
      decode_en_q  <= (state_d == S_DECODE);
      execute_en_q <= (state_d == S_EXECUTE);
      mem_req_q    <= (state_d == S_MEMORY);
      wb_en_q      <= (state_d == S_WRITEBACK);
      pc_en_q      <= (state_d == S_PCUPD);
      halted_q     <= (state_d == S_STOP);
    end
  end

  assign pc_o            = pc_q;
  assign cc_o            = cc_q;
  assign stage_o         = state_q;
  assign status_o        = status_q;
  assign retired_count_o = retired_q;
  assign fetch_en_o      = fetch_en_q;
  assign decode_en_o     = decode_en_q;
  assign execute_en_o    = execute_en_q;
  assign mem_req_o       = mem_req_q;
  assign wb_en_o         = wb_en_q;
  assign pc_en_o         = pc_en_q;
  assign halted_o        = halted_q;

endmodule

// File: doc/y86_seq_sequencer.md
# y86_seq_sequencer

Parametrised multi-cycle stage sequencer and architectural-state holder for the sequential Y86-64 core. It steps Fetch, Decode, Execute, Memory, Writeback and PC-update one stage per state instead of evaluating all stages in one combinational pass. It owns PC, condition codes, the status register and a retired-instruction counter, and supports a variable-latency data memory through a ready handshake. It halts cleanly into a STOP state instead of ending simulation.

## Interface
- ADDR_W, 64, width of PC and NewPC
- IMEM_BYTES, 256, first invalid instruction address; PC >= IMEM_BYTES is an address error
- RESET_PC, 0, PC value after reset
- CNT_W, 32, width of RetiredCount
- MEM_TIMEOUT, 16, MEMORY-state wait limit in cycles (used only with the watchdog macro)

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  leaves IDLE
- icode  in  4  from Fetch
- Fetch_HLT, Fetch_INS, Fetch_ADR  in  1 each  Fetch status flags
- DataMemError  in  1  data-memory out-of-bounds flag, valid with MemReady
- MemReady  in  1  data-memory access complete
- NewPC  in  ADDR_W  from PC_Update
- CC_Next  in  3  {ZF,SF,OF} from Execute
- PC  out  ADDR_W  program counter
- CC  out  3  {ZF,SF,OF}
- Stage  out  3  state encoding
- Fetch_En, Decode_En, Execute_En, Mem_Req, WB_En, PC_En  out  1 each  stage strobes
- Status  out  4  1=AOK, 2=ADR, 3=INS, 4=HLT
- Halted  out  1  high in STOP
- RetiredCount  out  CNT_W  number of completed instructions

## Operation
- States and Stage encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, STOP=7.
- Stage strobes are Moore outputs. Each strobe is high for exactly the cycles spent in its state; Mem_Req is high for every MEMORY cycle.
- IDLE → FETCH when Start=1. Start is ignored in every other state.
- FETCH: flags are sampled at the end of the cycle, with priority Fetch_HLT > Fetch_INS > (Fetch_ADR or PC >= IMEM_BYTES).
  - HLT: Status=4, RetiredCount+1, PC unchanged, go to STOP.
  - INS: Status=3, go to STOP.
  - ADR: Status=2, go to STOP.
  - No flag set: go to DECODE.
- DECODE → EXECUTE unconditionally.
- EXECUTE: CC ← CC_Next at the end of the cycle only if icode=6 (OPq).
  - Next state is MEMORY if icode ∈ {4,5,8,9,A,B}; otherwise WRITEBACK.
- MEMORY: the state holds while MemReady=0.
  - On MemReady=1 with DataMemError=1: Status=2, go to STOP. No writeback, no PC update.
  - On MemReady=1 with DataMemError=0: go to WRITEBACK.
- WRITEBACK → PCUPD.
- PCUPD: PC ← NewPC, RetiredCount+1, go to FETCH.
- STOP is terminal until Rst_n is asserted. Halted=1; PC, CC, Status and RetiredCount are frozen.
- RetiredCount wraps modulo 2^CNT_W. NewPC is taken at full ADDR_W width with no truncation.

## Timing
- Reset (asynchronous, any state, including mid-MEMORY): PC=RESET_PC, CC=3'b000, Stage=IDLE, all strobes 0, Status=1, Halted=0, RetiredCount=0.
- Instruction latency without memory access: 5 cycles (F, D, E, W, P).
- Instruction latency with memory access: 6 + N cycles, where N is the number of MEMORY cycles with MemReady=0.
- MemReady is sampled only in MEMORY; outside MEMORY it is ignored.
- The new PC is visible on the cycle FETCH is re-entered.
- The CC update from an OPq is visible from the first DECODE cycle onward.
- Status leaves 1 only on the edge that enters STOP.

## Configuration
- Macro: Y86_SEQ_MEM_WATCHDOG_EN.
- Defined: a wait counter clears on entry to MEMORY.
  - If MemReady is still 0 after MEM_TIMEOUT consecutive MEMORY cycles, the next edge sets Status=2 and enters STOP.
  - MemReady arriving in cycle MEM_TIMEOUT itself is accepted.
- Not defined: MEMORY waits indefinitely; no counter is built.

## Test plan
- Reset and start: Rst_n=0 then 1, Start=1 for one cycle, icode=1 (nop), NewPC=PC+1 → Stage walks 1,2,3,5,6, PC=1 after 5 cycles, RetiredCount=1, Mem_Req never high.
- Condition-code gating: icode=6 with CC_Next=3'b100 → CC=100. Next instruction icode=2 with CC_Next=3'b011 → CC stays 100.
- Memory wait: icode=5 with MemReady low for 3 MEMORY cycles → Mem_Req high for 4 cycles, instruction takes 9 cycles, PC=NewPC.
- Error stops: DataMemError=1 with MemReady=1 → Status=2, Halted=1, PC and RetiredCount unchanged. Separately, PC=256 at FETCH with IMEM_BYTES=256 → Status=2.
- Fetch priority: Fetch_HLT=1 and Fetch_INS=1 together → Status=4, RetiredCount+1. Start pulses in STOP have no effect.
- Async reset mid-MEMORY: Rst_n low while Mem_Req=1 → all outputs take reset values immediately. With Y86_SEQ_MEM_WATCHDOG_EN and MEM_TIMEOUT=4, MemReady held low → Status=2 after 4 MEMORY cycles.
